// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor computing
// a - b - bin LSB first through one full-subtractor cell and a borrow flop.
// Results and flags are held from the done cycle until the next operation
// completes; partial results live only in an internal shift register.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_done;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell operating on the current LSBs and the borrow flop
  assign w_x        = r_a_sr[0];
  assign w_y        = r_b_sr[0];
  assign w_d        = w_x ^ w_y ^ r_br;
  assign w_br_next  = (~w_x & w_y) | (~w_x & r_br) | (w_y & r_br);
  // The final difference bit enters from the MSB side, so after WIDTH
  // shifts the register holds the result in natural bit order.
  assign w_res_next = {w_d, r_res_sr[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign diff  = r_diff;
  assign bout  = r_bout;
  assign ovf   = r_ovf;
  assign zero  = r_zero;

  // Control FSM, serial datapath and registered result/flag outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_br     <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_res_sr <= w_res_next;
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_br     <= w_br_next;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            // Publish the completed result and flags together with done
            r_diff  <= w_res_next;
            r_bout  <= w_br_next;
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            r_zero  <= (w_res_next == '0);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
